// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and address legality check for the register file
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int R_ZERO     = 0;

  // An address is usable for read, write and reserve only if it names a real,
  // non-hardwired register.
  function automatic bit addr_legal(input logic [31:0] addr, input int depth,
                                    input bit zero_reg);
    return (addr < $unsigned(depth)) && !(zero_reg && (addr == $unsigned(R_ZERO)));
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - read/write/reserve bus of the multi-port register file
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve-over-write priority
module regfile_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  busy,
  output logic              any_busy
);

  // A same-edge reserve beats the clear: the write retires an older producer
  // while the reserve announces a newer one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set_en && (set_addr == ADDR_W'(i)))
          busy[i] <= 1'b1;
        else if (clr_en && (clr_addr == ADDR_W'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-read-port register file with write bypass and busy scoreboard
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_sb_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic                     wr_legal;
  logic                     rsv_legal;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]        ra;
  logic                     hit;
  logic                     rsv_hit;

  assign wr_legal  = bus.wr_en  && addr_legal(32'(bus.wr_addr),  DEPTH, ZERO_REG);
  assign rsv_legal = bus.rsv_en && addr_legal(32'(bus.rsv_addr), DEPTH, ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_legal) begin
      regs[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_legal),
    .set_addr (bus.rsv_addr),
    .clr_en   (wr_legal),
    .clr_addr (bus.wr_addr),
    .busy     (busy),
    .any_busy (bus.any_busy)
  );

  // Illegal addresses fall through to the zero defaults. A bypass hit hides the
  // busy bit unless this same edge re-reserves the register.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    hit       = 1'b0;
    rsv_hit   = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra      = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit     = BYPASS && wr_legal && (bus.wr_addr == ra);
      rsv_hit = bus.rsv_en && (bus.rsv_addr == ra);
      if (addr_legal(32'(ra), DEPTH, ZERO_REG)) begin
        rd_data_c[k*DATA_W +: DATA_W] = hit ? bus.wr_data : regs[ra[IDX_W-1:0]];
        rd_busy_c[k] = busy[ra[IDX_W-1:0]] && !(hit && !rsv_hit);
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed vector bench for the multi-port register file
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_a ();
  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_b ();
  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_c ();

  regfile_mp_sb #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  regfile_mp_sb #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  regfile_mp_sb #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.rd_addr = rd_addr;  assign if_b.rd_addr = rd_addr;  assign if_c.rd_addr = rd_addr;
  assign if_a.wr_en = wr_en;      assign if_b.wr_en = wr_en;      assign if_c.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr;  assign if_b.wr_addr = wr_addr;  assign if_c.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;  assign if_b.wr_data = wr_data;  assign if_c.wr_data = wr_data;
  assign if_a.rsv_en = rsv_en;    assign if_b.rsv_en = rsv_en;    assign if_c.rsv_en = rsv_en;
  assign if_a.rsv_addr = rsv_addr; assign if_b.rsv_addr = rsv_addr; assign if_c.rsv_addr = rsv_addr;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic        any;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic re, input logic [4:0] ra,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1, input logic any);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.any = any;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a0, input logic [4:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd_addr = {a1, a0};
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a0, a1);
  endtask

  initial begin
    // wa wd re ra | a0 a1 | d0 d1 b0 b1 any  (expectations for the BYPASS=1, DEPTH=32 instance)
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 1, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0,  3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0,  0, 3, 32'h0,        32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 3, 32'h0,        32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 7,  7, 7, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  7, 7, 32'h0,        32'h0,        1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  7, 7, 32'h0,        32'h0,        1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  7, 7, 32'h0,        32'h0,        1, 1, 1));
    vecs.push_back(mk(1, 7, 32'h55,       0, 0,  7, 3, 32'h55,       32'hDEADBEEF, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  7, 7, 32'h55,       32'h55,       0, 0, 0));
    vecs.push_back(mk(1, 9, 32'hAA,       1, 9,  9, 9, 32'hAA,       32'hAA,       0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  9, 9, 32'hAA,       32'hAA,       1, 1, 1));
    vecs.push_back(mk(1, 4, 32'h44,       1, 2,  2, 4, 32'h0,        32'h44,       0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  2, 4, 32'h0,        32'h44,       1, 0, 1));
    vecs.push_back(mk(1, 9, 32'h1,        0, 0,  9, 2, 32'h1,        32'h0,        0, 1, 1));
    vecs.push_back(mk(1, 2, 32'h2,        0, 0,  2, 9, 32'h2,        32'h1,        0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  2, 9, 32'h2,        32'h1,        0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 5,  5, 5, 32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 5, 32'h5,        1, 5,  5, 5, 32'h5,        32'h5,        1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  5, 5, 32'h5,        32'h5,        1, 1, 1));
    vecs.push_back(mk(1, 5, 32'h6,        0, 0,  5, 0, 32'h6,        32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  5, 0, 32'h6,        32'h0,        0, 0, 0));

    // reset state while rst is held
    idle(5'd0, 5'd1);
    #2;
    chk("rst_a_d0", if_a.rd_data[31:0], 32'h0);
    chk("rst_a_busy", {30'h0, if_a.rd_busy}, 32'h0);
    chk("rst_a_any", {31'h0, if_a.any_busy}, 32'h0);
    chk("rst_b_any", {31'h0, if_b.any_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].a0, vecs[i].a1);
      #1;
      chk($sformatf("v%0d_d0", i), if_a.rd_data[31:0], vecs[i].d0);
      chk($sformatf("v%0d_d1", i), if_a.rd_data[63:32], vecs[i].d1);
      chk($sformatf("v%0d_b0", i), {31'h0, if_a.rd_busy[0]}, {31'h0, vecs[i].b0});
      chk($sformatf("v%0d_b1", i), {31'h0, if_a.rd_busy[1]}, {31'h0, vecs[i].b1});
      chk($sformatf("v%0d_any", i), {31'h0, if_a.any_busy}, {31'h0, vecs[i].any});
    end

    // bypass vs no bypass: same-cycle write of r3
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    chk("byp_a_new", if_a.rd_data[31:0], 32'h12345678);
    chk("nobyp_b_old", if_b.rd_data[31:0], 32'hDEADBEEF);
    @(negedge clk);
    idle(5'd3, 5'd3);
    #1;
    chk("nobyp_b_next", if_b.rd_data[31:0], 32'h12345678);

    // raw busy without bypass during the completing write
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 5'd11, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd11, 32'h77, 1'b0, 5'd0, 5'd11, 5'd0);
    #1;
    chk("wr11_a_busy", {31'h0, if_a.rd_busy[0]}, 32'h0);
    chk("wr11_a_data", if_a.rd_data[31:0], 32'h77);
    chk("wr11_b_busy", {31'h0, if_b.rd_busy[0]}, 32'h1);
    chk("wr11_b_data", if_b.rd_data[31:0], 32'h0);
    @(negedge clk);
    idle(5'd11, 5'd0);
    #1;
    chk("post11_b_data", if_b.rd_data[31:0], 32'h77);
    chk("post11_b_busy", {31'h0, if_b.rd_busy[0]}, 32'h0);
    chk("post11_b_any", {31'h0, if_b.any_busy}, 32'h0);

    // out-of-range address on the DEPTH=16 instance
    @(negedge clk);
    drive(1'b1, 5'd20, 32'h00000BAD, 1'b1, 5'd20, 5'd20, 5'd4);
    #1;
    chk("oor_c_d0_same", if_c.rd_data[31:0], 32'h0);
    chk("oor_c_b0_same", {31'h0, if_c.rd_busy[0]}, 32'h0);
    @(negedge clk);
    idle(5'd20, 5'd4);
    #1;
    chk("oor_c_d0", if_c.rd_data[31:0], 32'h0);
    chk("oor_c_alias4", if_c.rd_data[63:32], 32'h44);
    chk("oor_c_any", {31'h0, if_c.any_busy}, 32'h0);
    chk("inr_a_d0", if_a.rd_data[31:0], 32'h00000BAD);
    chk("inr_a_b0", {31'h0, if_a.rd_busy[0]}, 32'h1);
    chk("inr_a_any", {31'h0, if_a.any_busy}, 32'h1);
    @(negedge clk);
    drive(1'b1, 5'd20, 32'h0, 1'b0, 5'd0, 5'd20, 5'd4);

    // asynchronous reset mid-cycle, then reset across a write edge
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234, 1'b1, 5'd6, 5'd5, 5'd6);
    @(negedge clk);
    idle(5'd5, 5'd6);
    #1;
    chk("pre_rst_d0", if_a.rd_data[31:0], 32'h1234);
    chk("pre_rst_any", {31'h0, if_a.any_busy}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_d0", if_a.rd_data[31:0], 32'h0);
    chk("async_rst_b1", {31'h0, if_a.rd_busy[1]}, 32'h0);
    chk("async_rst_any", {31'h0, if_a.any_busy}, 32'h0);
    drive(1'b1, 5'd8, 32'h99, 1'b1, 5'd8, 5'd8, 5'd6);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd8, 5'd6);
    #1;
    chk("rst_wr_dropped", if_a.rd_data[31:0], 32'h0);
    chk("rst_rsv_dropped", {31'h0, if_a.any_busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-read-port general-purpose register file for the multicycle CPU datapath. It replaces the latch-style, level-triggered register array with an edge-triggered write port and asynchronous reset. It adds an optional write-to-read bypass and a per-register busy scoreboard, so the control unit can stall on registers whose multicycle results are still pending. Register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of architectural registers (2..2^ADDR_W)
ADDR_W, 5, register address width
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes/reservations
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = register addressed by port k has a pending reservation
wr_en  in  1  write enable (RegWre)
wr_addr  in  ADDR_W  write register number
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve request: mark rsv_addr busy (result in flight)
rsv_addr  in  ADDR_W  register to reserve
any_busy  out  1  OR of all busy bits

Behaviour:
- One clock: clk. Reset is asynchronous and active-high: rst.
- Reset: while rst=1, all DEPTH registers are 0 and all busy bits are 0. Therefore rd_data=0, rd_busy=0 and any_busy=0 during and immediately after reset. Reset asserted mid-write discards the write.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data. Ignored if wr_addr>=DEPTH, or if ZERO_REG=1 and wr_addr=0.
- Read: combinational, zero latency. rd_data[k] = reg[rd_addr[k]].
- Read special cases:
  - rd_addr[k]>=DEPTH reads 0.
  - ZERO_REG=1 and address 0 reads 0.
- Bypass (BYPASS=1): if wr_en=1, wr_addr=rd_addr[k], and the write is legal (not r0 under ZERO_REG, in range), then rd_data[k]=wr_data in the same cycle. With BYPASS=0, the new value is visible only from the cycle after the edge.
- Multiple read ports may address the same register; all return the same value.
- Scoreboard, one busy bit per register, updated on the rising edge:
  - rsv_en=1 sets busy[rsv_addr].
  - A legal write (wr_en=1) clears busy[wr_addr].
  - Same edge, same address, reserve and write both asserted: reserve wins and busy stays 1 (the write completes an older producer; a new one is issued). The data write still occurs.
  - Same edge, different addresses: both take effect.
  - A reservation of r0 (ZERO_REG=1) or an out-of-range address is ignored.
  - Reserving an already-busy register leaves it busy (no counting).
- rd_busy[k] = busy[rd_addr[k]].
  - With BYPASS=1, it is forced to 0 when the port is bypass-hit that cycle and the same edge's reserve does not target that address.
  - With BYPASS=0, rd_busy is the raw busy bit.
- any_busy = OR of busy[0..DEPTH-1], registered state only (no bypass term).
- No latches. No combinational path from rsv_* to rd_data.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/DEPTH/ADDR_W/NUM_RD constants
  - localparam R_ZERO = 0
  - a function addr_legal(addr, DEPTH, ZERO_REG) shared by the write, reserve and read paths
- Sub-module regfile_scoreboard:
  - holds the DEPTH busy bits, the set/clear priority logic and any_busy
  - instantiated once
- The data array, read muxes and bypass stay in the top module.

Test Plan:
- Reset with rst high mid-cycle after loading r5=0x1234 -> rd_data for r5 reads 0 immediately (asynchronous); any_busy=0.
- Write r3=0xDEADBEEF with port0 reading r3 in the same cycle:
  - BYPASS=1 -> port0 shows 0xDEADBEEF that cycle.
  - BYPASS=0 -> old value, then 0xDEADBEEF next cycle.
- Write r0=0xFFFFFFFF with ZERO_REG=1 -> r0 reads 0 on all ports. Reserving r0 -> rd_busy=0 and any_busy=0.
- Reserve r7, then 3 idle cycles, then write r7=0x55 -> rd_busy=1 for 3 cycles. With BYPASS=1, rd_busy=0 and data=0x55 in the write cycle. any_busy falls after the edge.
- Reserve r9 and write r9=0xAA on the same edge -> r9 reads 0xAA and busy[r9] stays 1. Reserve r2 and write r4 together -> busy[r2]=1, busy[r4]=0.
- DEPTH=16, ADDR_W=5: write addr 20 -> no register changes; reading addr 20 returns 0.
